// File: rtl/fixed_point.sv
// FixedPoint: signed Q8.8 fixed-point type shared by the perceptron datapath
// and its controllers. ONE is the Q8.8 encoding of 1.0.
package FixedPoint;

    typedef logic signed [15:0] sfp;

    localparam sfp ONE = 16'sh0100;

endpackage

// File: rtl/perceptron_train_sequencer_pkg.sv
// TrainSeqPkg: state encoding and shared widths for perceptron_train_sequencer.
package TrainSeqPkg;

    typedef enum logic [2:0] {
        IDLE,
        TRAIN,
        EVAL,
        TEST,
        DONE
    } train_state_t;

    localparam int EPOCH_W = 8;

endpackage

// File: rtl/perceptron_train_sequencer_match_counter.sv
// match_counter: counts cycles where enable and match are both high.
// Clear has priority over counting; the count sticks at all-ones instead of
// wrapping back to zero.
module match_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         match,
    output logic [W-1:0] count
);

    // Saturating count register with synchronous reset and clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && match && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/perceptron_train_sequencer.sv
// perceptron_train_sequencer: drives a perceptron and its example ROM through
// train / evaluate epochs, stops early once an epoch evaluates fully correct
// (or the epoch limit is hit), then scores the test examples.
// Optional feature macro: PERCEPTRON_LR_DECAY_EN halves the learning rate on
// every return from EVAL to TRAIN, flooring at one LSB.
module perceptron_train_sequencer
    import FixedPoint::*;
    import TrainSeqPkg::*;
#(
    parameter int NUM_TRAIN  = 4,
    parameter int NUM_TEST   = 4,
    parameter int MAX_EPOCHS = 10,
    parameter int IDX_W      = $clog2(NUM_TRAIN + NUM_TEST)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  sfp                 lr_init,
    input  sfp                 prediction,
    input  sfp                 expected,
    output logic [IDX_W-1:0]   example,
    output logic               training,
    output sfp                 learning_rate,
    output logic               busy,
    output logic               done,
    output logic [EPOCH_W-1:0] epoch,
    output logic               converged,
    output logic [IDX_W:0]     test_correct
);

    localparam logic [IDX_W-1:0]   LAST_TRAIN = IDX_W'(NUM_TRAIN - 1);
    localparam logic [IDX_W-1:0]   FIRST_TEST = IDX_W'(NUM_TRAIN);
    localparam logic [IDX_W-1:0]   LAST_TEST  = IDX_W'(NUM_TRAIN + NUM_TEST - 1);
    localparam logic [IDX_W:0]     EVAL_ALMOST = (IDX_W+1)'(NUM_TRAIN - 1);
    localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(MAX_EPOCHS - 1);

    train_state_t       state, state_next;
    logic [IDX_W-1:0]   example_next;
    logic [EPOCH_W-1:0] epoch_next;
    logic               converged_next;
    sfp                 lr_next;
    logic               match;
    logic               eval_clear, eval_en;
    logic               test_clear, test_en;
    logic [IDX_W:0]     eval_count;

    assign match = (prediction == expected);

    match_counter #(.W(IDX_W + 1)) u_eval_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (eval_clear),
        .enable (eval_en),
        .match  (match),
        .count  (eval_count)
    );

    match_counter #(.W(IDX_W + 1)) u_test_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (test_clear),
        .enable (test_en),
        .match  (match),
        .count  (test_correct)
    );

    // State and run registers; reset aborts any run and discards its results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            example       <= '0;
            epoch         <= '0;
            converged     <= 1'b0;
            learning_rate <= '0;
        end else begin
            state         <= state_next;
            example       <= example_next;
            epoch         <= epoch_next;
            converged     <= converged_next;
            learning_rate <= lr_next;
        end
    end

    // Next-state and control decode; the final EVAL sample is folded into the
    // convergence decision because the counter only sees it on the next edge.
    always_comb begin
        state_next     = state;
        example_next   = example;
        epoch_next     = epoch;
        converged_next = converged;
        lr_next        = learning_rate;
        eval_clear     = 1'b0;
        eval_en        = 1'b0;
        test_clear     = 1'b0;
        test_en        = 1'b0;
        training       = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_next     = TRAIN;
                    example_next   = '0;
                    epoch_next     = '0;
                    converged_next = 1'b0;
                    lr_next        = lr_init;
                    eval_clear     = 1'b1;
                    test_clear     = 1'b1;
                end
            end
            TRAIN: begin
                busy       = 1'b1;
                training   = 1'b1;
                eval_clear = 1'b1;
                if (example == LAST_TRAIN) begin
                    state_next   = EVAL;
                    example_next = '0;
                end else begin
                    example_next = example + IDX_W'(1);
                end
            end
            EVAL: begin
                busy    = 1'b1;
                eval_en = 1'b1;
                if (example == LAST_TRAIN) begin
                    if ((eval_count == EVAL_ALMOST) && match) begin
                        converged_next = 1'b1;
                        state_next     = TEST;
                        example_next   = FIRST_TEST;
                    end else if (epoch == LAST_EPOCH) begin
                        state_next   = TEST;
                        example_next = FIRST_TEST;
                    end else begin
                        state_next   = TRAIN;
                        example_next = '0;
                        epoch_next   = epoch + EPOCH_W'(1);
`ifdef PERCEPTRON_LR_DECAY_EN
                        if (learning_rate != sfp'(1)) begin
                            lr_next = learning_rate >>> 1;
                        end
`else
                        lr_next = learning_rate;
`endif
                    end
                end else begin
                    example_next = example + IDX_W'(1);
                end
            end
            TEST: begin
                busy    = 1'b1;
                test_en = 1'b1;
                if (example == LAST_TEST) begin
                    state_next = DONE;
                end else begin
                    example_next = example + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// tb_perceptron_train_sequencer: directed self-checking bench using a
// combinational stub in place of the perceptron and its example ROM.
// Honours PERCEPTRON_LR_DECAY_EN when deciding the expected learning rate.
module tb_perceptron_train_sequencer;
    import FixedPoint::*;

    logic       clk;
    logic       rst;
    logic       start;
    sfp         lr_init;
    sfp         prediction;
    sfp         expected;
    logic [2:0] example;
    logic       training;
    sfp         learning_rate;
    logic       busy;
    logic       done;
    logic [7:0] epoch;
    logic       converged;
    logic [3:0] test_correct;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         mode = 1;
    logic [7:0] mask = 8'hFF;

    perceptron_train_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .lr_init       (lr_init),
        .prediction    (prediction),
        .expected      (expected),
        .example       (example),
        .training      (training),
        .learning_rate (learning_rate),
        .busy          (busy),
        .done          (done),
        .epoch         (epoch),
        .converged     (converged),
        .test_correct  (test_correct)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure run length in clock cycles.
    always @(posedge clk) cyc <= cyc + 1;

    // Stub ROM/perceptron: 0 never matches, 1 always matches, 2 matches per
    // mask bit, 3 misses example 1 until epoch 2 and matches otherwise.
    always_comb begin
        expected   = ONE;
        prediction = 16'sh0000;
        case (mode)
            1:       prediction = ONE;
            2:       prediction = mask[example] ? ONE : 16'sh0000;
            3:       prediction = ((epoch >= 8'd2) || (example != 3'd1)) ? ONE : 16'sh0000;
            default: prediction = 16'sh0000;
        endcase
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    // Expected learning rate at the start of epoch e.
    function automatic sfp expLr(input int e);
        sfp v;
        v = ONE;
`ifdef PERCEPTRON_LR_DECAY_EN
        for (int i = 0; i < e; i++) begin
            if (v != sfp'(1)) v = v >>> 1;
        end
`endif
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] required);
        checks++;
        assert (observed === required) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, required);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_example"},   32'(example),       32'd0);
        checkOutput({tag, "_training"},  32'(training),      32'd0);
        checkOutput({tag, "_lr"},        32'(learning_rate), 32'd0);
        checkOutput({tag, "_busy"},      32'(busy),          32'd0);
        checkOutput({tag, "_done"},      32'(done),          32'd0);
        checkOutput({tag, "_epoch"},     32'(epoch),         32'd0);
        checkOutput({tag, "_converged"}, 32'(converged),     32'd0);
        checkOutput({tag, "_testcorr"},  32'(test_correct),  32'd0);
    endtask

    // Pulse start for one cycle; returns at the first TRAIN cycle.
    task automatic applyStimulus(input sfp lr);
        @(negedge clk);
        lr_init = lr;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    // Wait (bounded) for done and check the cycle count from the first TRAIN.
    task automatic waitDone(input string tag, input int required_cycles);
        int n;
        n = 0;
        while (!done && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"},   32'(done),     32'd1);
        checkOutput({tag, "_cycles"}, 32'(cyc - t0), 32'(required_cycles));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        lr_init = ONE;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] run A: always-correct stub");
        mode = 1;
        applyStimulus(ONE);
        checkOutput("a_train",   32'(training),      32'd1);
        checkOutput("a_busy",    32'(busy),          32'd1);
        checkOutput("a_example", 32'(example),       32'd0);
        checkOutput("a_lr",      32'(learning_rate), 32'(ONE));
        waitDone("a", 12);
        checkOutput("a_epoch",     32'(epoch),        32'd0);
        checkOutput("a_converged", 32'(converged),    32'd1);
        checkOutput("a_testcorr",  32'(test_correct), 32'd4);
        checkOutput("a_idle_busy", 32'(busy),         32'd0);

        $display("[TB] run B: never-correct stub, start pulsed during TEST");
        mode = 0;
        applyStimulus(ONE);
        for (int e = 0; e < 10; e++) begin
            checkOutput("b_epoch_idx", 32'(epoch),         32'(e));
            checkOutput("b_lr_epoch",  32'(learning_rate), 32'(expLr(e)));
            checkOutput("b_training",  32'(training),      32'd1);
            repeat (8) @(negedge clk);
        end
        checkOutput("b_test_busy",  32'(busy),     32'd1);
        checkOutput("b_test_train", 32'(training), 32'd0);
        checkOutput("b_test_first", 32'(example),  32'd4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("b_not_yet_done", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("b_done",      32'(done),          32'd1);
        checkOutput("b_cycles",    32'(cyc - t0),      32'd84);
        checkOutput("b_epoch",     32'(epoch),         32'd9);
        checkOutput("b_converged", 32'(converged),     32'd0);
        checkOutput("b_testcorr",  32'(test_correct),  32'd0);
        checkOutput("b_busy",      32'(busy),          32'd0);
        checkOutput("b_lr_final",  32'(learning_rate), 32'(expLr(9)));
        repeat (5) @(negedge clk);
        checkOutput("b_hold_done",  32'(done),  32'd1);
        checkOutput("b_hold_epoch", 32'(epoch), 32'd9);

        $display("[TB] run C: restart from DONE, partial test matches");
        mode = 2;
        mask = 8'b0101_1111;
        applyStimulus(ONE);
        checkOutput("c_epoch_clr",    32'(epoch),        32'd0);
        checkOutput("c_conv_clr",     32'(converged),    32'd0);
        checkOutput("c_testcorr_clr", 32'(test_correct), 32'd0);
        waitDone("c", 12);
        checkOutput("c_converged", 32'(converged),    32'd1);
        checkOutput("c_testcorr",  32'(test_correct), 32'd2);

        $display("[TB] run D: converge in epoch 2");
        mode = 3;
        applyStimulus(ONE);
        waitDone("d", 28);
        checkOutput("d_epoch",     32'(epoch),        32'd2);
        checkOutput("d_converged", 32'(converged),    32'd1);
        checkOutput("d_testcorr",  32'(test_correct), 32'd4);

        $display("[TB] run E: reset during EVAL of epoch 2");
        mode = 0;
        applyStimulus(ONE);
        repeat (21) @(negedge clk);
        checkOutput("e_epoch",   32'(epoch),    32'd2);
        checkOutput("e_eval",    32'(training), 32'd0);
        checkOutput("e_example", 32'(example),  32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("midrst");
        rst  = 1'b0;
        mode = 1;
        applyStimulus(ONE);
        waitDone("e_after", 12);
        checkOutput("e_converged", 32'(converged),    32'd1);
        checkOutput("e_testcorr",  32'(test_correct), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
